// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared types and timing defaults for the SDRAM bank timer.
//   bank_state_e : per-bank state (IDLE, OPENING, OPEN, CLOSING)
//   cmd_e        : command opcode (ACT, PRE, PREA, REF)
//   DEF_*        : default geometry and timing parameters (cycles)
//   timer_width  : counter width able to hold the largest timing value
package sdram_pkg;

    typedef enum logic [1:0] {
        BANK_IDLE    = 2'd0,
        BANK_OPENING = 2'd1,
        BANK_OPEN    = 2'd2,
        BANK_CLOSING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        CMD_ACT  = 2'd0,
        CMD_PRE  = 2'd1,
        CMD_PREA = 2'd2,
        CMD_REF  = 2'd3
    } cmd_e;

    localparam int unsigned DEF_ROW_WIDTH       = 14;
    localparam int unsigned DEF_NUM_GROUPS      = 2;
    localparam int unsigned DEF_BANKS_PER_GROUP = 4;
    localparam int unsigned DEF_T_RCD           = 8;
    localparam int unsigned DEF_T_RP            = 5;
    localparam int unsigned DEF_T_RAS           = 12;
    localparam int unsigned DEF_T_RRD           = 2;
    localparam int unsigned DEF_T_RFC           = 20;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a down-counter that must hold the largest of the timing values.
    function automatic int unsigned timer_width(
        input int unsigned t_rcd,
        input int unsigned t_rp,
        input int unsigned t_ras,
        input int unsigned t_rrd,
        input int unsigned t_rfc
    );
        int unsigned m;
        m = max_u(max_u(max_u(t_rcd, t_rp), max_u(t_ras, t_rrd)), t_rfc);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sdram_bank_fsm.sv
// sdram_bank_fsm
//   State, latched row and tRAS counter for a single SDRAM bank.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     act_go      : ACT accepted for this bank (only acted on in IDLE)
//     pre_go      : PRE/PREA accepted for this bank (only acted on in OPEN)
//     act_row     : row to latch on ACT
//     state       : current bank_state_e encoding
//     row         : row latched at the last ACT
//     tras_done   : tRAS counter has reached zero
module sdram_bank_fsm
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int unsigned T_RCD     = DEF_T_RCD,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned T_RAS     = DEF_T_RAS,
    parameter int unsigned CNT_W     = timer_width(DEF_T_RCD, DEF_T_RP, DEF_T_RAS,
                                                   DEF_T_RRD, DEF_T_RFC)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 act_go,
    input  logic                 pre_go,
    input  logic [ROW_WIDTH-1:0] act_row,
    output logic [1:0]           state,
    output logic [ROW_WIDTH-1:0] row,
    output logic                 tras_done
);

    bank_state_e          state_q, state_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [CNT_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]     tras_q, tras_d;

    // phase counts the remaining cycles of OPENING/CLOSING. It is loaded with
    // T-1 so the transition lands exactly T edges after the accepting edge.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        phase_d = phase_q;
        tras_d  = (tras_q == '0) ? '0 : tras_q - CNT_W'(1);
        case (state_q)
            BANK_IDLE: begin
                if (act_go) begin
                    state_d = BANK_OPENING;
                    row_d   = act_row;
                    phase_d = CNT_W'(T_RCD - 1);
                    tras_d  = CNT_W'(T_RAS);
                end
            end
            BANK_OPENING: begin
                if (phase_q == '0) begin
                    state_d = BANK_OPEN;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            BANK_OPEN: begin
                if (pre_go) begin
                    state_d = BANK_CLOSING;
                    phase_d = CNT_W'(T_RP - 1);
                end
            end
            BANK_CLOSING: begin
                if (phase_q == '0) begin
                    state_d = BANK_IDLE;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            default: state_d = BANK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_IDLE;
            row_q   <= '0;
            phase_q <= '0;
            tras_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            tras_q  <= tras_d;
        end
    end

    assign state     = state_q;
    assign row       = row_q;
    assign tras_done = (tras_q == '0);

endmodule

// File: rtl/sdram_bank_timer.sv
// sdram_bank_timer
//   Tracks per-bank SDRAM state and enforces tRCD, tRP, tRAS, tRRD (per bank
//   group) and tRFC, telling the requester which command is legal this cycle.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     cmd_valid       : command offered
//     cmd_ready       : offered command is legal this cycle (combinational)
//     cmd_type        : cmd_e opcode
//     cmd_bank        : target bank (ignored for PREA/REF)
//     cmd_row         : row for ACT
//     bank_state      : per-bank bank_state_e
//     open_row        : per-bank row latched at ACT
//     bank_ready      : per-bank OPEN flag
//     refresh_busy    : refresh in progress
//     q_bank, q_row   : row-hit query inputs
//     q_hit           : queried bank is OPEN on the queried row
module sdram_bank_timer
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_WIDTH       = DEF_ROW_WIDTH,
    parameter int unsigned NUM_GROUPS      = DEF_NUM_GROUPS,
    parameter int unsigned BANKS_PER_GROUP = DEF_BANKS_PER_GROUP,
    parameter int unsigned T_RCD           = DEF_T_RCD,
    parameter int unsigned T_RP            = DEF_T_RP,
    parameter int unsigned T_RAS           = DEF_T_RAS,
    parameter int unsigned T_RRD           = DEF_T_RRD,
    parameter int unsigned T_RFC           = DEF_T_RFC
)(
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   cmd_valid,
    output logic                                                   cmd_ready,
    input  logic [1:0]                                             cmd_type,
    input  logic [$clog2(NUM_GROUPS*BANKS_PER_GROUP)-1:0]          cmd_bank,
    input  logic [ROW_WIDTH-1:0]                                   cmd_row,
    output logic [NUM_GROUPS*BANKS_PER_GROUP-1:0][1:0]             bank_state,
    output logic [NUM_GROUPS*BANKS_PER_GROUP-1:0][ROW_WIDTH-1:0]   open_row,
    output logic [NUM_GROUPS*BANKS_PER_GROUP-1:0]                  bank_ready,
    output logic                                                   refresh_busy,
    input  logic [$clog2(NUM_GROUPS*BANKS_PER_GROUP)-1:0]          q_bank,
    input  logic [ROW_WIDTH-1:0]                                   q_row,
    output logic                                                   q_hit
);

    localparam int unsigned BANKS  = NUM_GROUPS * BANKS_PER_GROUP;
    localparam int unsigned BANK_W = $clog2(BANKS);
    localparam int unsigned GRP_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned CNT_W  = timer_width(T_RCD, T_RP, T_RAS, T_RRD, T_RFC);

    cmd_e                 cmd_kind;
    logic                 cmd_accept;
    logic [GRP_W-1:0]     cmd_group;

    logic [BANKS-1:0]     bank_idle;
    logic [BANKS-1:0]     bank_open;
    logic [BANKS-1:0]     bank_transit;
    logic [BANKS-1:0]     tras_done;
    logic [BANKS-1:0]     prea_block;
    logic [BANKS-1:0]     act_go;
    logic [BANKS-1:0]     pre_go;

    logic [NUM_GROUPS-1:0] rrd_zero;

    logic [CNT_W-1:0]     ref_cnt_q, ref_cnt_d;

    always_comb begin
        cmd_kind  = cmd_e'(cmd_type);
        cmd_group = GRP_W'(32'(cmd_bank) / BANKS_PER_GROUP);
    end

    // Readiness looks only at registered state, so a timer expiring on the
    // same edge as an offered command still blocks it for that edge.
    always_comb begin
        cmd_ready = 1'b0;
        case (cmd_kind)
            CMD_ACT:  cmd_ready = bank_idle[cmd_bank] && !refresh_busy && rrd_zero[cmd_group];
            CMD_PRE:  cmd_ready = (bank_open[cmd_bank] && tras_done[cmd_bank]) || bank_idle[cmd_bank];
            CMD_PREA: cmd_ready = !(|bank_transit) && !refresh_busy && !(|prea_block);
            CMD_REF:  cmd_ready = (&bank_idle) && !refresh_busy;
            default:  cmd_ready = 1'b0;
        endcase
    end

    assign cmd_accept = cmd_valid && cmd_ready;

    // Per-bank command steering and status decode. PREA is broadcast; banks
    // that are not OPEN ignore it inside the bank FSM.
    for (genvar i = 0; i < BANKS; i++) begin : g_bank
        assign act_go[i]       = cmd_accept && (cmd_kind == CMD_ACT) && (cmd_bank == BANK_W'(i));
        assign pre_go[i]       = cmd_accept && ((cmd_kind == CMD_PREA) ||
                                 ((cmd_kind == CMD_PRE) && (cmd_bank == BANK_W'(i))));
        assign bank_idle[i]    = (bank_state[i] == BANK_IDLE);
        assign bank_open[i]    = (bank_state[i] == BANK_OPEN);
        assign bank_transit[i] = (bank_state[i] == BANK_OPENING) || (bank_state[i] == BANK_CLOSING);
        assign prea_block[i]   = bank_open[i] && !tras_done[i];

        sdram_bank_fsm #(
            .ROW_WIDTH (ROW_WIDTH),
            .T_RCD     (T_RCD),
            .T_RP      (T_RP),
            .T_RAS     (T_RAS),
            .CNT_W     (CNT_W)
        ) u_bank_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .act_go    (act_go[i]),
            .pre_go    (pre_go[i]),
            .act_row   (cmd_row),
            .state     (bank_state[i]),
            .row       (open_row[i]),
            .tras_done (tras_done[i])
        );
    end

    // One tRRD counter per bank group: ACTs into different groups do not
    // throttle each other.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_rrd
        logic [CNT_W-1:0] rrd_cnt_q, rrd_cnt_d;

        always_comb begin
            rrd_cnt_d = (rrd_cnt_q == '0) ? '0 : rrd_cnt_q - CNT_W'(1);
            if (cmd_accept && (cmd_kind == CMD_ACT) && (cmd_group == GRP_W'(g))) begin
                rrd_cnt_d = CNT_W'(T_RRD);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rrd_cnt_q <= '0;
            end else begin
                rrd_cnt_q <= rrd_cnt_d;
            end
        end

        assign rrd_zero[g] = (rrd_cnt_q == '0);
    end

    // Refresh is busy while the counter is non-zero: loaded with T_RFC at the
    // accepting edge, it clears exactly T_RFC edges later.
    always_comb begin
        ref_cnt_d = (ref_cnt_q == '0) ? '0 : ref_cnt_q - CNT_W'(1);
        if (cmd_accept && (cmd_kind == CMD_REF)) begin
            ref_cnt_d = CNT_W'(T_RFC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
        end
    end

    assign refresh_busy = (ref_cnt_q != '0);
    assign bank_ready   = bank_open;
    assign q_hit        = bank_open[q_bank] && (open_row[q_bank] == q_row);

endmodule

// File: tb/tb_sdram_bank_timer.sv
// tb_sdram_bank_timer
//   Directed, table-driven bench for sdram_bank_timer at default parameters,
//   followed by hand-written multi-cycle sequences for timing corners.
module tb_sdram_bank_timer;
    import sdram_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [2:0]        cmd_bank;
    logic [13:0]       cmd_row;
    logic [7:0][1:0]   bank_state;
    logic [7:0][13:0]  open_row;
    logic [7:0]        bank_ready;
    logic              refresh_busy;
    logic [2:0]        q_bank;
    logic [13:0]       q_row;
    logic              q_hit;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    sdram_bank_timer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_bank     (cmd_bank),
        .cmd_row      (cmd_row),
        .bank_state   (bank_state),
        .open_row     (open_row),
        .bank_ready   (bank_ready),
        .refresh_busy (refresh_busy),
        .q_bank       (q_bank),
        .q_row        (q_row),
        .q_hit        (q_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  ctype;
        logic [2:0]  bank;
        logic [13:0] row;
        int unsigned idle;
        logic [2:0]  qb;
        logic [13:0] qr;
        logic        exp_ready;
        logic [15:0] exp_state;
        logic        exp_hit;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [2:0] b, input logic [13:0] r);
        cmd_valid = v;
        cmd_type  = t;
        cmd_bank  = b;
        cmd_row   = r;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, CMD_ACT, 3'd0, 14'h0);
        q_bank = 3'd0;
        q_row  = 14'h0;

        // Edge numbering in comments is relative to the first table edge E0.
        vecs[0]  = '{1'b1, CMD_ACT,  3'd0, 14'h010, 0,  3'd0, 14'h010, 1'b1, 16'h0001, 1'b0}; // E0 ACT b0
        vecs[1]  = '{1'b1, CMD_ACT,  3'd1, 14'h033, 0,  3'd0, 14'h010, 1'b0, 16'h0001, 1'b0}; // same group, tRRD
        vecs[2]  = '{1'b1, CMD_ACT,  3'd5, 14'h020, 0,  3'd5, 14'h020, 1'b1, 16'h0401, 1'b0}; // other group ok
        vecs[3]  = '{1'b1, CMD_REF,  3'd0, 14'h000, 0,  3'd5, 14'h020, 1'b0, 16'h0401, 1'b0}; // banks busy
        vecs[4]  = '{1'b1, CMD_PREA, 3'd0, 14'h000, 10, 3'd5, 14'h020, 1'b0, 16'h0802, 1'b1}; // opening blocks
        vecs[5]  = '{1'b0, CMD_ACT,  3'd0, 14'h000, 0,  3'd5, 14'h010, 1'b0, 16'h0802, 1'b0}; // row miss
        vecs[6]  = '{1'b1, CMD_PRE,  3'd1, 14'h000, 0,  3'd0, 14'h010, 1'b1, 16'h0802, 1'b1}; // PRE idle no-op
        vecs[7]  = '{1'b1, CMD_PREA, 3'd0, 14'h000, 0,  3'd5, 14'h020, 1'b1, 16'h0C03, 1'b0}; // E17 PREA
        vecs[8]  = '{1'b1, CMD_ACT,  3'd0, 14'h010, 3,  3'd0, 14'h010, 1'b0, 16'h0C03, 1'b0}; // still closing
        vecs[9]  = '{1'b0, CMD_ACT,  3'd0, 14'h000, 0,  3'd0, 14'h010, 1'b0, 16'h0000, 1'b0}; // IDLE at E22
        vecs[10] = '{1'b1, CMD_REF,  3'd0, 14'h000, 0,  3'd0, 14'h010, 1'b1, 16'h0000, 1'b0}; // REF accepted
        vecs[11] = '{1'b1, CMD_ACT,  3'd2, 14'h000, 0,  3'd2, 14'h000, 1'b0, 16'h0000, 1'b0}; // ACT in refresh

        // Reset state
        do_reset();
        #1;
        check("rst_state", 32'(bank_state), 32'h0);
        check("rst_ready_busy_hit", {22'd0, bank_ready, refresh_busy, q_hit}, 32'h0);
        check("rst_row0", 32'(open_row[0]), 32'h0);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].ctype, vecs[i].bank, vecs[i].row);
            q_bank = vecs[i].qb;
            q_row  = vecs[i].qr;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].exp_ready));
            tick();
            cmd_valid = 1'b0;
            for (int k = 0; k < int'(vecs[i].idle); k++) tick();
            #1;
            check($sformatf("vec%0d_state", i), 32'(bank_state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_hit", i), 32'(q_hit), 32'(vecs[i].exp_hit));
        end

        // ACT bank 3: OPENING for T_RCD edges, then OPEN with the latched row
        do_reset();
        drive(1'b1, CMD_ACT, 3'd3, 14'h155);
        #1 check("a_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a_opening_%0d", k), {29'd0, bank_ready[3], bank_state[3]}, 32'(3'b001));
            tick();
        end
        check("a_open", {29'd0, bank_ready[3], bank_state[3]}, 32'(3'b110));
        check("a_row", 32'(open_row[3]), 32'h155);

        // PRE held after ACT: refused until tRAS counter reaches zero
        do_reset();
        drive(1'b1, CMD_ACT, 3'd0, 14'h001);
        #1 check("b_act_ready", 32'(cmd_ready), 32'h1);
        tick();
        drive(1'b1, CMD_PRE, 3'd0, 14'h000);
        for (int k = 0; k <= 12; k++) begin
            #1 check($sformatf("b_pre_ready_%0d", k), 32'(cmd_ready), (k == 12) ? 32'h1 : 32'h0);
            tick();
        end
        cmd_valid = 1'b0;
        check("b_closing_first", 32'(bank_state[0]), 32'(BANK_CLOSING));
        repeat (4) tick();
        check("b_closing_last", 32'(bank_state[0]), 32'(BANK_CLOSING));
        tick();
        check("b_idle", 32'(bank_state[0]), 32'(BANK_IDLE));

        // Refresh: busy for T_RFC cycles, ACT refused throughout
        do_reset();
        drive(1'b1, CMD_REF, 3'd0, 14'h000);
        #1 check("c_ref_ready", 32'(cmd_ready), 32'h1);
        tick();
        drive(1'b1, CMD_ACT, 3'd2, 14'h007);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("c_busy_%0d", k), {30'd0, refresh_busy, cmd_ready}, 32'(2'b10));
            tick();
        end
        check("c_done", {30'd0, refresh_busy, cmd_ready}, 32'(2'b01));
        cmd_valid = 1'b0;
        check("c_no_act", 32'(bank_state), 32'h0);

        // Asynchronous reset while bank 6 is OPENING
        do_reset();
        drive(1'b1, CMD_ACT, 3'd6, 14'h02A);
        #1 check("d_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        q_bank = 3'd6;
        q_row  = 14'h02A;
        tick();
        tick();
        check("d_opening", 32'(bank_state[6]), 32'(BANK_OPENING));
        #2 rst_n = 1'b0;
        #1;
        check("d_async_state", 32'(bank_state), 32'h0);
        check("d_async_row", 32'(open_row[6]), 32'h0);
        check("d_async_ready", 32'(bank_ready), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, CMD_ACT, 3'd6, 14'h02B);
        #1 check("d_post_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        check("d_post_state", 32'(bank_state[6]), 32'(BANK_OPENING));
        check("d_post_row", 32'(open_row[6]), 32'h02B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
